// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and constants for the RAT MCU interrupt controller
package intr_pkg;

    // Controller handshake states with the control-unit FSM
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    // Interrupt service routine address, also used by the PC mux
    localparam logic [9:0] ISR_VECTOR = 10'h3FF;

    // Width of a source index; a single source still needs one bit
    function automatic int id_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - per-source synchroniser with edge or level event detection
module intr_sync
    import intr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;

    // Metastability chain; reset clears it so a source held high through
    // reset shows up as a fresh rising edge once reset is released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

    generate
        if (EDGE_MODE) begin : g_edge
            logic history;

            // One cycle of history on the synchronised value for rise detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    history <= 1'b0;
                end else begin
                    history <= synced;
                end
            end

            assign evt = synced & ~history;
        end else begin : g_level
            assign evt = synced;
        end
    endgenerate

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: pending latch, priority select, control-unit handshake
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int  NUM_SRC     = 4,
    parameter int  SYNC_STAGES = 2,
    parameter bit  EDGE_MODE   = 1'b1,
    localparam int ID_W        = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] intr_in,
    input  logic               i_set,
    input  logic               i_clr,
    input  logic               int_ack,
    input  logic               retie,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic               i_flg,
    output logic               in_service,
    output logic               flg_shad_ld,
    output logic               flg_ld_sel
);

    intr_state_t        state;
    intr_state_t        state_nxt;
    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] ack_mask;
    logic [ID_W-1:0]    top_id;
    logic               i_flg_nxt;
    logic               take_ack;
    logic               take_retie;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            intr_sync #(
                .SYNC_STAGES(SYNC_STAGES),
                .EDGE_MODE  (EDGE_MODE)
            ) u_sync (
                .clk(clk),
                .rst(rst),
                .raw(intr_in[g]),
                .evt(evt[g])
            );
        end
    endgenerate

    // Acknowledge and return only count in the state that expects them
    assign take_ack   = int_ack && (state == REQ);
    assign take_retie = retie && (state == SERVICE);

    // Priority encoder: lowest-numbered pending source wins
    always_comb begin
        top_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                top_id = ID_W'(i);
            end
        end
    end

    // Clear only the acknowledged source; a same-cycle event re-sets it
    always_comb begin
        ack_mask = '0;
        if (take_ack) begin
            ack_mask[top_id] = 1'b1;
        end
        pending_nxt = (pending & ~ack_mask) | evt;
    end

    // Interrupt-enable flag: handshake forcing overrides SEI/CLI, CLI beats SEI
    always_comb begin
        i_flg_nxt = i_flg;
        if (take_ack) begin
            i_flg_nxt = 1'b0;
        end else if (take_retie) begin
            i_flg_nxt = 1'b1;
        end else if (i_clr) begin
            i_flg_nxt = 1'b0;
        end else if (i_set) begin
            i_flg_nxt = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        int_req     = 1'b0;
        in_service  = 1'b0;
        flg_shad_ld = 1'b0;
        flg_ld_sel  = 1'b0;
        case (state)
            IDLE: begin
                if (i_flg && (|pending)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                int_req     = 1'b1;
                flg_shad_ld = int_ack;
                if (int_ack) begin
                    state_nxt = SERVICE;
                end else if (!i_flg_nxt) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                in_service = 1'b1;
                flg_ld_sel = retie;
                if (retie) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pending latch, enable flag and serviced-source id
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            i_flg   <= 1'b0;
            int_id  <= '0;
        end else begin
            pending <= pending_nxt;
            i_flg   <= i_flg_nxt;
            if (take_ack) begin
                int_id <= top_id;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl
module tb_intr_ctrl;

    localparam int N = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] intr_in = '0;
    logic         i_set = 1'b0;
    logic         i_clr = 1'b0;
    logic         int_ack = 1'b0;
    logic         retie = 1'b0;

    logic       e_req, e_flg, e_svc, e_shad, e_ldsel;
    logic [1:0] e_id;
    logic       l_req, l_flg, l_svc, l_shad, l_ldsel;
    logic [1:0] l_id;
    logic [6:0] e_vec;

    assign e_vec = {e_req, e_id, e_flg, e_svc, e_shad, e_ldsel};

    intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S), .EDGE_MODE(1'b1)) u_edge (
        .clk(clk), .rst(rst), .intr_in(intr_in), .i_set(i_set), .i_clr(i_clr),
        .int_ack(int_ack), .retie(retie), .int_req(e_req), .int_id(e_id),
        .i_flg(e_flg), .in_service(e_svc), .flg_shad_ld(e_shad), .flg_ld_sel(e_ldsel)
    );

    intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S), .EDGE_MODE(1'b0)) u_level (
        .clk(clk), .rst(rst), .intr_in(intr_in), .i_set(i_set), .i_clr(i_clr),
        .int_ack(int_ack), .retie(retie), .int_req(l_req), .int_id(l_id),
        .i_flg(l_flg), .in_service(l_svc), .flg_shad_ld(l_shad), .flg_ld_sel(l_ldsel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; intr_in = '0; i_set = 0; i_clr = 0; int_ack = 0; retie = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_req(input bit lvl, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if ((lvl ? l_req : e_req) === 1'b1) break;
            step();
        end
        check(name, lvl ? l_req : e_req, 1);
    endtask

    // Reference model: sample history, pending set, flag and handshake phase
    logic [N-1:0] mq [0:S];
    logic [N-1:0] m_pend;
    logic [1:0]   m_id;
    logic         m_flg, m_req, m_svc;

    task automatic model_reset();
        for (int k = 0; k <= S; k++) mq[k] = '0;
        m_pend = '0; m_id = 0; m_flg = 0; m_req = 0; m_svc = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] ev, lowbit;
        logic ack_t, ret_t, nflg;
        ev = mq[S-1] & ~mq[S];
        for (int k = S; k > 0; k--) mq[k] = mq[k-1];
        mq[0] = intr_in;
        lowbit = m_pend & (~m_pend + 1'b1);
        ack_t = m_req & int_ack;
        ret_t = m_svc & retie;
        nflg = ack_t ? 1'b0 : ret_t ? 1'b1 : i_clr ? 1'b0 : i_set ? 1'b1 : m_flg;
        if (ack_t)
            for (int k = 0; k < N; k++) if (lowbit == (4'd1 << k)) m_id = 2'(k);
        if (m_req) begin
            if (ack_t) begin m_req = 0; m_svc = 1; end
            else if (!nflg) m_req = 0;
        end else if (m_svc) begin
            if (ret_t) m_svc = 0;
        end else if (m_flg && m_pend != 0) begin
            m_req = 1;
        end
        m_pend = (m_pend & ~(ack_t ? lowbit : '0)) | ev;
        m_flg = nflg;
    endtask

    typedef struct {
        logic [3:0] intr;
        logic       set, clr, ack, ret;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;

        // {intr, set, clr, ack, ret, {req, id, flg, svc, shad_ld, ld_sel}}
        tbl[0]  = '{4'h0, 1, 0, 0, 0, 7'b0_00_0_0_0_0};
        tbl[1]  = '{4'h4, 0, 0, 0, 0, 7'b0_00_1_0_0_0};
        tbl[2]  = '{4'h0, 0, 0, 0, 0, 7'b0_00_1_0_0_0};
        tbl[3]  = '{4'h0, 0, 0, 0, 0, 7'b0_00_1_0_0_0};
        tbl[4]  = '{4'h0, 0, 0, 0, 0, 7'b0_00_1_0_0_0};
        tbl[5]  = '{4'h0, 0, 0, 1, 0, 7'b1_00_1_0_1_0};
        tbl[6]  = '{4'h0, 0, 0, 0, 0, 7'b0_10_0_1_0_0};
        tbl[7]  = '{4'h0, 1, 0, 0, 0, 7'b0_10_0_1_0_0};
        tbl[8]  = '{4'h0, 0, 0, 0, 0, 7'b0_10_1_1_0_0};
        tbl[9]  = '{4'h0, 0, 0, 0, 1, 7'b0_10_1_1_0_1};
        tbl[10] = '{4'h0, 0, 0, 0, 0, 7'b0_10_1_0_0_0};
        tbl[11] = '{4'h0, 0, 0, 0, 1, 7'b0_10_1_0_0_0};
        tbl[12] = '{4'h0, 0, 0, 1, 0, 7'b0_10_1_0_0_0};
        tbl[13] = '{4'h0, 1, 1, 0, 0, 7'b0_10_1_0_0_0};
        tbl[14] = '{4'h0, 0, 0, 0, 0, 7'b0_10_0_0_0_0};
        tbl[15] = '{4'h0, 0, 0, 0, 0, 7'b0_10_0_0_0_0};

        // Reset held with every source high
        rst = 1'b1; intr_in = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_outs%0d", k), e_vec, 0);
            check($sformatf("rst_lvl_outs%0d", k), {l_req, l_id, l_flg, l_svc, l_shad, l_ldsel}, 0);
        end
        rst = 1'b0;
        i_set = 1; step(); i_set = 0;
        for (int k = 0; k < N; k++) begin
            wait_req(0, 12, $sformatf("rst_req%0d", k));
            int_ack = 1; step(); int_ack = 0;
            check($sformatf("rst_id%0d", k), e_id, k);
            retie = 1; step(); retie = 0;
        end
        cnt = 0;
        repeat (20) begin step(); if (e_req) cnt++; end
        check("rst_once", cnt, 0);

        // Basic sequence and single-cycle corner events
        do_reset();
        for (int i = 0; i < 16; i++) begin
            intr_in = tbl[i].intr; i_set = tbl[i].set; i_clr = tbl[i].clr;
            int_ack = tbl[i].ack; retie = tbl[i].ret;
            #1;
            check($sformatf("vec%0d", i), e_vec, tbl[i].exp);
            @(posedge clk); #1;
        end
        i_set = 0; i_clr = 0; int_ack = 0; retie = 0;

        // Priority between two simultaneous sources
        do_reset();
        i_set = 1; step(); i_set = 0;
        intr_in = 4'b1010; step(); intr_in = 0;
        wait_req(0, 10, "pri_req1");
        int_ack = 1; #1 check("pri_shad", e_shad, 1);
        step(); int_ack = 0;
        check("pri_id1", e_id, 1);
        check("pri_flg0", e_flg, 0);
        check("pri_svc", e_svc, 1);
        retie = 1; #1 check("pri_ldsel", e_ldsel, 1);
        step(); retie = 0;
        check("pri_flg1", e_flg, 1);
        wait_req(0, 5, "pri_req2");
        int_ack = 1; step(); int_ack = 0;
        check("pri_id3", e_id, 3);
        retie = 1; step(); retie = 0;

        // Masking by the I flag, and CLI while requesting
        do_reset();
        intr_in = 4'h1; step(); intr_in = 0;
        cnt = 0;
        repeat (20) begin step(); if (e_req) cnt++; end
        check("mask_noreq", cnt, 0);
        i_set = 1; step(); i_set = 0;
        check("mask_req_early", e_req, 0);
        step();
        check("mask_req", e_req, 1);
        i_clr = 1; step(); i_clr = 0;
        check("mask_drop", e_req, 0);
        check("mask_flg", e_flg, 0);
        i_set = 1; step(); i_set = 0; step();
        check("mask_kept", e_req, 1);
        int_ack = 1; step(); int_ack = 0;
        check("mask_id", e_id, 0);
        retie = 1; step(); retie = 0;

        // New edge on the source being acknowledged
        do_reset();
        i_set = 1; step(); i_set = 0;
        intr_in = 4'h4; step(); intr_in = 0;
        wait_req(0, 10, "ackedge_req1");
        intr_in = 4'h4; step(); step();
        int_ack = 1; step(); int_ack = 0;
        check("ackedge_id", e_id, 2);
        retie = 1; step(); retie = 0; step();
        check("ackedge_rereq", e_req, 1);
        int_ack = 1; step(); int_ack = 0;
        check("ackedge_id2", e_id, 2);
        retie = 1; step(); retie = 0;
        intr_in = 0;

        // Level mode: a held source is serviced after every return
        do_reset();
        i_set = 1; step(); i_set = 0;
        intr_in = 4'h1;
        for (int k = 0; k < 3; k++) begin
            wait_req(1, 10, $sformatf("lvl_req%0d", k));
            int_ack = 1; step(); int_ack = 0;
            check($sformatf("lvl_svc%0d", k), {l_svc, l_id}, 3'b1_00);
            step();
            retie = 1; step(); retie = 0;
        end
        intr_in = 0;

        // Randomised traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(5) == 0) intr_in[b] = ~intr_in[b];
            i_set   = ($urandom_range(3) == 0);
            i_clr   = ($urandom_range(9) == 0);
            int_ack = m_req ? ($urandom_range(1) == 0) : ($urandom_range(9) == 0);
            retie   = m_svc ? ($urandom_range(3) == 0) : ($urandom_range(9) == 0);
            #1;
            check($sformatf("rand%0d", c), e_vec,
                  {m_req, m_id, m_flg, m_svc, m_req & int_ack, m_svc & retie});
            model_edge();
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
